up_counter_7b: RTL and testbench

//  - Free-running synchronous binary up-counter, 7 bits by default.
//  - Advances by one on every rising CLK edge. Wraps from MAX_VAL to 0.
//  - Used as a general-purpose event/cycle counter and timebase.
//  - Provides a terminal-count flag and a one-cycle wrap pulse for downstream sequencing.

---
 rtl/up_counter_7b_if.sv | 12 +
 rtl/up_counter_7b.sv | 48 ++++
 tb/tb_up_counter_7b.sv | 125 ++++++++++++
 3 files changed

// File: rtl/up_counter_7b_if.sv
// Output bundle of up_counter_7b: count, terminal-count flag and wrap pulse.
// The counter drives it through the master modport; consumers read it through slave.
interface up_counter_7b_if #(
  parameter int unsigned WIDTH = 7
);
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (output q, output tc, output wrap);
  modport slave  (input  q, input  tc, input  wrap);
endinterface

// File: rtl/up_counter_7b.sv
// Free-running up-counter with terminal-count decode and a registered wrap pulse.
// Define UP_COUNTER_SATURATE_EN to hold at MAX_VAL instead of wrapping (wrap stays 0).
module up_counter_7b #(
  parameter int unsigned      WIDTH   = 7,
  parameter logic [WIDTH-1:0] MAX_VAL = WIDTH'((64'd1 << WIDTH) - 64'd1)
) (
  input  logic             CLK,
  input  logic             Reset,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_max;

  assign at_max = (count_q == MAX_VAL);

  always_comb begin
    count_d = count_q + 1'b1;
    wrap_d  = 1'b0;
    if (at_max) begin
`ifdef UP_COUNTER_SATURATE_EN
      count_d = MAX_VAL;
`else
      count_d = '0;
      wrap_d  = 1'b1;
`endif
    end
  end

  // Reset is sampled on the clock only, so it has no path to q or wrap between edges.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = count_q;
  assign tc   = at_max;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_up_counter_7b.sv
// Directed bench for up_counter_7b: vector table plus hand sequences for wrap,
// reset-on-wrap, clock-only reset sampling and a 200-edge run.
module tb_up_counter_7b;
  localparam int W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  up_counter_7b_if #(.WIDTH(W)) cnt_if ();

  up_counter_7b #(.WIDTH(W)) dut (
    .CLK   (clk),
    .Reset (rst),
    .q     (cnt_if.q),
    .tc    (cnt_if.tc),
    .wrap  (cnt_if.wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    int           edges;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] eq, input logic et, input logic ew);
    chk({tag, ".q"},    32'(cnt_if.q),    32'(eq));
    chk({tag, ".tc"},   32'(cnt_if.tc),   32'(et));
    chk({tag, ".wrap"}, 32'(cnt_if.wrap), 32'(ew));
  endtask

  initial begin
    // reset, then 4 counting edges
    tbl.push_back('{1'b1, 1,   7'd0,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 1,   7'd1,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 1,   7'd2,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 1,   7'd3,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 1,   7'd4,   1'b0, 1'b0});
    // reset held for 5 edges
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 1, 7'd0, 1'b0, 1'b0});
    // count to 50, single reset edge, resume
    tbl.push_back('{1'b0, 50,  7'd50,  1'b0, 1'b0});
    tbl.push_back('{1'b1, 1,   7'd0,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 1,   7'd1,   1'b0, 1'b0});
    tbl.push_back('{1'b1, 1,   7'd0,   1'b0, 1'b0});
    // 127 edges reach the terminal count
    tbl.push_back('{1'b0, 127, 7'd127, 1'b1, 1'b0});
`ifdef UP_COUNTER_SATURATE_EN
    tbl.push_back('{1'b0, 1,   7'd127, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1,   7'd127, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 126, 7'd127, 1'b1, 1'b0});
`else
    tbl.push_back('{1'b0, 1,   7'd0,   1'b0, 1'b1});
    tbl.push_back('{1'b0, 1,   7'd1,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 126, 7'd127, 1'b1, 1'b0});
`endif
    // reset on the edge where q == 127 beats the wrap
    tbl.push_back('{1'b1, 1,   7'd0,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 1,   7'd1,   1'b0, 1'b0});

    #2;
    for (int v = 0; v < tbl.size(); v++) begin
      rst = tbl[v].rst;
      for (int e = 0; e < tbl[v].edges; e++) step();
      chk_all($sformatf("vec%0d", v), tbl[v].q, tbl[v].tc, tbl[v].wrap);
    end

    // Reset raised between edges must not touch q until the next edge.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 0; e < 10; e++) step();
    chk("mid.pre_q", 32'(cnt_if.q), 32'd10);
    #2;
    rst = 1'b1;
    #1;
    chk("mid.no_async_q", 32'(cnt_if.q), 32'd10);
    step();
    chk("mid.sync_q", 32'(cnt_if.q), 32'd0);
    rst = 1'b0;
    step();
    chk("mid.resume_q", 32'(cnt_if.q), 32'd1);

    // 200 edges from 0, every edge checked against an edge-count model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      logic [W-1:0] eq;
      logic         ew;
      step();
`ifdef UP_COUNTER_SATURATE_EN
      eq = (e >= 127) ? 7'd127 : W'(e);
      ew = 1'b0;
`else
      eq = W'(e % 128);
      ew = (e == 128);
`endif
      chk_all($sformatf("run%0d", e), eq, (eq == 7'd127), ew);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
